// File: rtl/pattern_loader.sv
// Serial master that shifts a frame of bytes into the pattern buffer MSB-first
// over sclk/sin, and returns the displaced buffer contents as a readback stream.
module pattern_loader #(
  parameter int buffer_size  = 22,
  parameter int buffer_width = 8,
  parameter int half_period  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [buffer_width-1:0] byte_in,
  input  logic                    byte_valid,
  output logic                    byte_ready,
  output logic                    sclk,
  output logic                    sin,
  input  logic                    sout,
  output logic [buffer_width-1:0] rd_byte,
  output logic                    rd_valid,
  output logic                    busy,
  output logic                    done
);

  localparam int bit_w   = (buffer_width > 1) ? $clog2(buffer_width) : 1;
  localparam int byte_w  = $clog2(buffer_size + 1);
  localparam int phase_w = $clog2(half_period + 1);

  typedef enum logic [1:0] {IDLE, WAIT_BYTE, LOW, HIGH} state_t;

  state_t                  state_reg, state_next;
  logic                    sclk_reg, sclk_next;
  logic                    sin_reg, sin_next;
  logic [buffer_width-1:0] tx_reg, tx_next;
  logic [buffer_width-1:0] cap_reg, cap_next;
  logic [bit_w-1:0]        bit_cnt_reg, bit_cnt_next;
  logic [byte_w-1:0]       byte_cnt_reg, byte_cnt_next;
  logic [phase_w-1:0]      phase_reg, phase_next;
  logic [buffer_width-1:0] rd_byte_reg, rd_byte_next;
  logic                    rd_valid_reg, rd_valid_next;
  logic                    busy_reg, busy_next;
  logic                    done_reg, done_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= IDLE;
      sclk_reg     <= 1'b0;
      sin_reg      <= 1'b0;
      tx_reg       <= '0;
      cap_reg      <= '0;
      bit_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      phase_reg    <= '0;
      rd_byte_reg  <= '0;
      rd_valid_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      sclk_reg     <= sclk_next;
      sin_reg      <= sin_next;
      tx_reg       <= tx_next;
      cap_reg      <= cap_next;
      bit_cnt_reg  <= bit_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      phase_reg    <= phase_next;
      rd_byte_reg  <= rd_byte_next;
      rd_valid_reg <= rd_valid_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    sclk_next     = sclk_reg;
    sin_next      = sin_reg;
    tx_next       = tx_reg;
    cap_next      = cap_reg;
    bit_cnt_next  = bit_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    phase_next    = phase_reg;
    rd_byte_next  = rd_byte_reg;
    rd_valid_next = 1'b0;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    byte_ready    = 1'b0;

    case (state_reg)
      IDLE: begin
        // done_reg is still high in the cycle after completion; a start there is dropped
        if (start && !done_reg) begin
          state_next    = WAIT_BYTE;
          busy_next     = 1'b1;
          byte_cnt_next = '0;
        end
      end

      WAIT_BYTE: begin
        byte_ready = 1'b1;
        sclk_next  = 1'b0;
        if (byte_valid) begin
          tx_next      = byte_in;
          sin_next     = byte_in[buffer_width-1];
          bit_cnt_next = '0;
          phase_next   = '0;
          state_next   = LOW;
        end
      end

      LOW: begin
        if (phase_reg == phase_w'(half_period - 1)) begin
          // sout sampled on the same edge that raises sclk, before the buffer shifts
          sclk_next  = 1'b1;
          cap_next   = {cap_reg[buffer_width-2:0], sout};
          phase_next = '0;
          state_next = HIGH;
        end else begin
          phase_next = phase_reg + phase_w'(1);
        end
      end

      HIGH: begin
        if (phase_reg == phase_w'(half_period - 1)) begin
          sclk_next  = 1'b0;
          phase_next = '0;
          if (bit_cnt_reg != bit_w'(buffer_width - 1)) begin
            bit_cnt_next = bit_cnt_reg + bit_w'(1);
            tx_next      = {tx_reg[buffer_width-2:0], 1'b0};
            sin_next     = tx_reg[buffer_width-2];
            state_next   = LOW;
          end else begin
            rd_byte_next  = cap_reg;
            rd_valid_next = 1'b1;
            byte_cnt_next = byte_cnt_reg + byte_w'(1);
            if (byte_cnt_reg == byte_w'(buffer_size - 1)) begin
              done_next  = 1'b1;
              busy_next  = 1'b0;
              sin_next   = 1'b0;
              state_next = IDLE;
            end else begin
              state_next = WAIT_BYTE;
            end
          end
        end else begin
          phase_next = phase_reg + phase_w'(1);
        end
      end

      default: state_next = IDLE;
    endcase
  end

  assign sclk     = sclk_reg;
  assign sin      = sin_reg;
  assign rd_byte  = rd_byte_reg;
  assign rd_valid = rd_valid_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule

// File: tb/tb_pattern_loader.sv
// Directed bench for pattern_loader: a half_period=1 instance driving a pattern
// buffer model, plus a half_period=3 instance whose sclk/sin timing is measured.
module tb_pattern_loader;

  localparam int NB = 22;
  localparam int LIM = 5000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, byte_valid, byte_ready, sclk, sin, sout, rd_valid, busy, done;
  logic [7:0] byte_in, rd_byte;
  logic       reset_b, start_b, byte_ready_b, sclk_b, sin_b, rd_valid_b, busy_b, done_b;
  logic [7:0] rd_byte_b;

  pattern_loader #(.buffer_size(NB), .buffer_width(8), .half_period(1)) dut (
    .clk(clk), .reset(reset), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .sclk(sclk), .sin(sin), .sout(sout), .rd_byte(rd_byte),
    .rd_valid(rd_valid), .busy(busy), .done(done));

  pattern_loader #(.buffer_size(NB), .buffer_width(8), .half_period(3)) dut_b (
    .clk(clk), .reset(reset_b), .start(start_b), .byte_in(8'h5A), .byte_valid(1'b1),
    .byte_ready(byte_ready_b), .sclk(sclk_b), .sin(sin_b), .sout(1'b0), .rd_byte(rd_byte_b),
    .rd_valid(rd_valid_b), .busy(busy_b), .done(done_b));

  // Pattern buffer model: one long shift chain, pattern[k] = flat[8k+7:8k]
  logic [8*NB-1:0] flat, load_val;
  logic            load;
  always @(posedge sclk or posedge load)
    if (load) flat = load_val;
    else      flat = {flat[8*NB-2:0], sin};
  assign sout = flat[8*NB-1];

  int edges = 0;
  always @(posedge sclk) edges++;
  int done_cnt = 0;
  logic [7:0] rd_q[$];
  always @(negedge clk) begin
    if (done === 1'b1) done_cnt++;
    if (rd_valid === 1'b1) rd_q.push_back(rd_byte);
  end

  // Timing monitor for the half_period=3 instance
  int cyc_b = 0, len_b = 0, rise_b = 0, last_first = 0;
  int hi_bad = 0, lo_bad = 0, sp_bad = 0, sp_chk = 0, sin_bad = 0;
  logic prev_sclk_b, prev_sin_b;
  always @(negedge clk) begin
    cyc_b++;
    if (reset_b) begin
      len_b = 0;
    end else begin
      if (sin_b !== prev_sin_b && sclk_b === 1'b1) sin_bad++;
      if (sclk_b === prev_sclk_b) len_b++;
      else begin
        if (prev_sclk_b === 1'b1) begin
          if (len_b != 3) hi_bad++;
        end else begin
          if (rise_b % 8 != 0) begin
            if (len_b != 3) lo_bad++;
          end else if (rise_b > 0) begin
            sp_chk++;
            if (cyc_b - last_first != 49) sp_bad++;
          end
          if (rise_b % 8 == 0) last_first = cyc_b;
          rise_b++;
        end
        len_b = 1;
      end
    end
    prev_sclk_b = sclk_b;
    prev_sin_b  = sin_b;
  end

  int tests = 0, fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input int mode);
    for (int k = 0; k < NB; k++) load_val[8*k +: 8] = (mode == 0) ? 8'(k) : 8'h00;
    load = 1'b1;
    #1 load = 1'b0;
  endtask

  task automatic start_pulse();
    byte_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] d);
    int n = 0;
    while (byte_ready !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("byte_ready_wait", byte_ready, 1'b1);
    byte_in = d;
    byte_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    int e0, d0, q0, n, gap_bad;
    logic s0;
    reset = 1'b1; reset_b = 1'b1; start = 1'b0; start_b = 1'b0;
    byte_in = 8'h00; byte_valid = 1'b0; load = 1'b0; load_val = '0;
    repeat (3) @(negedge clk);
    check("rst_sclk", sclk, 1'b0);
    check("rst_sin", sin, 1'b0);
    check("rst_byte_ready", byte_ready, 1'b0);
    check("rst_rd_byte", rd_byte, 8'h00);
    check("rst_rd_valid", rd_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    reset = 1'b0; reset_b = 1'b0;

    // Frame 1: pattern[k]=k preloaded, send 0xA0+j, start pulsed in the done cycle
    preload(0);
    e0 = edges; d0 = done_cnt; q0 = rd_q.size();
    start_pulse();
    check("busy_after_start", busy, 1'b1);
    for (int j = 0; j < NB; j++) send_byte(8'hA0 + 8'(j));
    wait_done();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    check("f1_edges", edges - e0, 176);
    check("f1_done_cnt", done_cnt - d0, 1);
    check("f1_busy", busy, 1'b0);
    check("f1_no_restart", byte_ready, 1'b0);
    for (int j = 0; j < NB; j++) check("f1_pattern", flat[8*(NB-1-j) +: 8], 8'hA0 + 8'(j));
    check("f1_rd_count", rd_q.size() - q0, NB);
    for (int k = 0; k < NB; k++) check("f1_readback", rd_q[q0+k], 8'(NB-1-k));

    // Frame 2: all 0xFF, start pulse mid-frame, 10-cycle stall after byte 5
    e0 = edges; d0 = done_cnt; q0 = rd_q.size();
    start_pulse();
    gap_bad = 0;
    for (int j = 0; j < NB; j++) begin
      send_byte(8'hFF);
      if (j == 2) begin
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      if (j == 5) begin
        byte_valid = 1'b0;
        n = 0;
        while (byte_ready !== 1'b1 && n < LIM) begin
          @(negedge clk);
          n++;
        end
        s0 = sin;
        for (int i = 0; i < 10; i++) begin
          if (sclk !== 1'b0 || sin !== s0 || byte_ready !== 1'b1) gap_bad++;
          @(negedge clk);
        end
      end
    end
    wait_done();
    repeat (4) @(negedge clk);
    check("f2_gap_bad", gap_bad, 0);
    check("f2_edges", edges - e0, 176);
    check("f2_done_cnt", done_cnt - d0, 1);
    check("f2_busy", busy, 1'b0);
    for (int j = 0; j < NB; j++) check("f2_pattern", flat[8*j +: 8], 8'hFF);
    check("f2_rd_count", rd_q.size() - q0, NB);
    for (int k = 0; k < NB; k++) check("f2_readback", rd_q[q0+k], 8'hA0 + 8'(k));

    // Frame 3: reset while sclk is high for bit 4 of byte 3
    preload(1);
    e0 = edges; d0 = done_cnt; q0 = rd_q.size();
    start_pulse();
    for (int j = 0; j < 4; j++) send_byte(8'h11 * 8'(j + 1));
    n = 0;
    while (edges - e0 < 29 && n < LIM) begin
      @(negedge clk);
      n++;
    end
    check("f3_reached_29", edges - e0, 29);
    check("f3_sclk_high", sclk, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("f3_sclk", sclk, 1'b0);
    check("f3_sin", sin, 1'b0);
    check("f3_busy", busy, 1'b0);
    check("f3_done", done, 1'b0);
    repeat (5) @(negedge clk);
    check("f3_edges", edges - e0, 29);
    check("f3_no_done", done_cnt - d0, 0);
    check("f3_rd_count", rd_q.size() - q0, 3);

    // Frame 4: full reload after the aborted frame
    e0 = edges; d0 = done_cnt;
    start_pulse();
    for (int j = 0; j < NB; j++) send_byte(8'h30 + 8'(j));
    wait_done();
    repeat (2) @(negedge clk);
    check("f4_edges", edges - e0, 176);
    check("f4_done_cnt", done_cnt - d0, 1);
    for (int j = 0; j < NB; j++) check("f4_pattern", flat[8*(NB-1-j) +: 8], 8'h30 + 8'(j));

    // half_period=3 timing frame
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 4 * LIM) begin
      @(negedge clk);
      n++;
    end
    check("hp3_done_seen", done_b, 1'b1);
    repeat (2) @(negedge clk);
    check("hp3_rises", rise_b, 176);
    check("hp3_high_width_bad", hi_bad, 0);
    check("hp3_low_width_bad", lo_bad, 0);
    check("hp3_sin_during_high", sin_bad, 0);
    check("hp3_spacing_checks", sp_chk, NB - 1);
    check("hp3_spacing_bad", sp_bad, 0);
    check("hp3_busy", busy_b, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pattern_loader.md
Name: pattern_loader

Overview:
- Serial master that fills the pattern buffer over its sclk/sin/sout serial port, driving the protocol from the transmitter end.
- Accepts a frame of buffer_size bytes through a valid/ready byte interface and serialises them MSB-first as sclk edges and sin levels in the clk domain.
- Captures the old buffer contents returning on sout and presents them as a readback byte stream.
- Sits between the host/config interface and the pattern buffer; runs on the same clk.

Parameters:
- buffer_size, 22, bytes per frame; must equal the pattern buffer depth.
- buffer_width, 8, bits per byte.
- half_period, 2, clk cycles per sclk low phase and per sclk high phase; minimum 1.

Ports:
- clk  input  1  system clock; everything is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a frame; honoured only in IDLE.
- byte_in  input  buffer_width  next byte to send.
- byte_valid  input  1  byte_in is valid.
- byte_ready  output  1  loader accepts byte_in this cycle.
- sclk  output  1  serial clock to the pattern buffer; registered.
- sin  output  1  serial data to the pattern buffer; registered.
- sout  input  1  serial data from the pattern buffer, i.e. the MSB of its last byte.
- rd_byte  output  buffer_width  byte shifted out of the buffer.
- rd_valid  output  1  one-cycle strobe that qualifies rd_byte.
- busy  output  1  a frame is in progress.
- done  output  1  one-cycle pulse when the frame completes.

Behaviour:
- Reset values: sclk=0, sin=0, byte_ready=0, rd_byte=0, rd_valid=0, busy=0, done=0. State=IDLE, all counters 0.
- States: IDLE, WAIT_BYTE, LOW, HIGH.
- IDLE:
  - start=1 -> WAIT_BYTE, busy<=1, byte count cleared.
  - Otherwise hold.
- WAIT_BYTE:
  - byte_ready=1 combinationally in this state only. sclk is held 0.
  - On byte_valid=1 (accept edge e): latch byte_in, sin<=byte_in[buffer_width-1], go to LOW, bit count=0.
  - While byte_valid=0, stall indefinitely. No sclk edges are generated.
- LOW:
  - sclk=0 for half_period cycles; sin is stable throughout.
  - At the final LOW edge: sclk<=1, sample sout into the readback shift register LSB (shift left), go to HIGH.
  - sout is sampled in the same edge that raises sclk, so the pattern buffer has not yet shifted.
- HIGH:
  - sclk=1 for half_period cycles; sin is held unchanged.
  - At the final HIGH edge: sclk<=0.
  - If bits remain: sin<=next lower bit, go to LOW.
  - Otherwise (byte complete): rd_byte<=captured byte, rd_valid<=1 for one cycle, byte count++.
    - If the count reached buffer_size: done<=1 for one cycle, busy<=0, sin<=0, go to IDLE.
    - Else go to WAIT_BYTE.
- Timing per bit: exactly 2*half_period clk cycles. sclk high and low widths are each exactly half_period.
  - Each byte takes 16*half_period cycles plus at least one WAIT_BYTE cycle.
  - A frame produces exactly buffer_size*buffer_width rising sclk edges.
- Ordering: the first byte accepted lands in pattern[buffer_size-1]; the last accepted lands in pattern[0]. Bits go MSB first.
- Readback: the k-th rd_byte is the pre-frame content of pattern[buffer_size-1-k].
- start outside IDLE, including in the same cycle as done, is ignored.
- byte_valid outside WAIT_BYTE is ignored; byte_in is not sampled.
- Reset mid-frame: next cycle all outputs return to their reset values.
  - No extra sclk rising edge is produced; dropping sclk from 1 to 0 is harmless.
  - The partially shifted buffer contents are left as-is. No done or rd_valid is issued.
- Counters: bit count width is clog2(buffer_width); byte count width is clog2(buffer_size+1); phase counter width is clog2(half_period+1).

Test Plan:
- Full frame, half_period=1: start, then bytes 0xA0+j for j=0..21 with byte_valid held high, against a behavioural pattern-buffer model.
  - Required: model pattern[21-j]=0xA0+j, exactly 176 sclk rising edges, a single done pulse, busy low afterwards.
- Readback: preload the model with pattern[k]=k, run a frame of 0xFF bytes.
  - Required: 22 rd_valid pulses with rd_byte=21,20,...,0 in order, and all model bytes equal 0xFF.
- Stall: drop byte_valid for 10 cycles after byte 5.
  - Required: sclk stays 0 and sin is constant during the gap, byte_ready=1 throughout, total edges still 176, final contents correct.
- Timing, half_period=3: measure sclk.
  - Required: every high and low width is 3 cycles.
  - sin changes only on the falling-edge clk and never while sclk=1.
  - Byte-to-byte spacing is 48 cycles plus WAIT_BYTE cycles.
- Reset mid-byte: assert reset for one cycle while in HIGH of bit 4 of byte 3.
  - Required next cycle: sclk=0, sin=0, busy=0, no done. Exactly 3*8+5=29 edges were produced.
  - A new start then loads a full frame correctly.
- start pulsed while busy, and in the done cycle: ignored.
  - Required: edge count unchanged and no second frame begins.
